// File: rtl/v_hier_qcap_if.sv
// Output handshake bundle for the qvec change-capture buffer.
// The master side presents the head entry; the slave side accepts it.
interface v_hier_qcap_if #(
   parameter int WIDTH = 4
);
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;

   modport master (
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      output out_ready
   );
endinterface

// File: rtl/v_hier_qcap.sv
// Captures every sampled change of qvec into a small FIFO, drained over valid/ready.
// Dropped changes (FIFO full with no simultaneous pop) raise a sticky overflow flag.
module v_hier_qcap #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_l,
   input  logic [WIDTH-1:0]         qvec,
   v_hier_qcap_if.master            out_if,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] s2;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   logic chg;
   logic pop;
   logic full;
   logic push_ok;
   logic push_drop;

   // A pop in the same cycle frees the slot a full FIFO needs for the new push.
   always_comb begin
      chg       = (s1 != s2);
      pop       = out_if.out_valid & out_if.out_ready;
      full      = (level == LW'(DEPTH));
      push_ok   = chg & (~full | pop);
      push_drop = chg & full & ~pop;
   end

   assign out_if.out_valid = (level != '0);
   assign out_if.out_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         s1       <= '0;
         s2       <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         s1 <= qvec;
         s2 <= s1;

         if (push_ok) begin
            mem[wr_ptr] <= s1;
            wr_ptr      <= wr_ptr + 1'b1;
         end

         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end

         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         // A drop in the same cycle as a clear keeps the flag set.
         if (push_drop) begin
            overflow <= 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_v_hier_qcap.sv
// Self-checking bench for v_hier_qcap: directed scenarios plus a randomized run
// compared against a queue-based reference model of the change-capture buffer.
module tb_v_hier_qcap;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;

   logic             clk;
   logic             reset_l;
   logic [WIDTH-1:0] qvec;
   logic [2:0]       level;
   logic             overflow;
   logic             clr_ovf;

   int checks;
   int errors;

   int delivered[$];

   // Reference model: stored entries, last sampled value, and a change awaiting push.
   int   m_q[$];
   int   m_last;
   logic m_pend;
   int   m_pend_val;
   logic m_ovf;

   v_hier_qcap_if #(.WIDTH(WIDTH)) out_if ();

   v_hier_qcap #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset_l  (reset_l),
      .qvec     (qvec),
      .out_if   (out_if),
      .level    (level),
      .overflow (overflow),
      .clr_ovf  (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic model_reset();
      m_q.delete();
      m_last     = 0;
      m_pend     = 1'b0;
      m_pend_val = 0;
      m_ovf      = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] qv, input logic rdy, input logic clr);
      logic rej;
      rej = 1'b0;
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (m_pend) begin
         if (m_q.size() < DEPTH) m_q.push_back(m_pend_val);
         else rej = 1'b1;
      end
      if (rej) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_pend     = (int'(qv) != m_last);
      m_pend_val = int'(qv);
      m_last     = int'(qv);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_l          = 1'b0;
      qvec             = '0;
      out_if.out_ready = 1'b0;
      clr_ovf          = 1'b0;
      model_reset();
      delivered.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_l = 1'b1;
   endtask

   // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
   task automatic step(input logic [3:0] qv, input logic rdy, input logic clr);
      @(negedge clk);
      qvec             = qv;
      out_if.out_ready = rdy;
      clr_ovf          = clr;
      if (out_if.out_valid && rdy) delivered.push_back(int'(out_if.out_data));
      model_edge(qv, rdy, clr);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (out_if.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", out_if.out_valid);
      end
      checks++;
      if (level !== 3'd0) begin
         errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow);
      end
      checks++;
      if (out_if.out_data !== 4'h0) begin
         errors++; $display("[TB] FAIL reset_data: got %0h expected 0", out_if.out_data);
      end
   endtask

   task automatic test_basic_capture();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(4'h0, 1'b1, 1'b0);
         checks++;
         if (out_if.out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_zero_valid: got %0b expected 0", out_if.out_valid);
         end
      end
      step(4'h5, 1'b1, 1'b0);
      checks++;
      if (out_if.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL basic_early_valid: got %0b expected 0", out_if.out_valid);
      end
      step(4'h5, 1'b1, 1'b0);
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_data !== 4'h5) begin
         errors++;
         $display("[TB] FAIL basic_valid_data: got valid %0b data %0h expected valid 1 data 5",
                  out_if.out_valid, out_if.out_data);
      end
      checks++;
      if (level !== 3'd1) begin
         errors++; $display("[TB] FAIL basic_level_one: got %0d expected 1", level);
      end
      step(4'h5, 1'b1, 1'b0);
      checks++;
      if (out_if.out_valid !== 1'b0 || level !== 3'd0) begin
         errors++;
         $display("[TB] FAIL basic_drained: got valid %0b level %0d expected valid 0 level 0",
                  out_if.out_valid, level);
      end
   endtask

   task automatic test_no_change();
      int exp_vals[3];
      exp_vals = '{3, 9, 3};
      do_reset();
      step(4'h3, 1'b1, 1'b0);
      step(4'h3, 1'b1, 1'b0);
      step(4'h3, 1'b1, 1'b0);
      step(4'h9, 1'b1, 1'b0);
      step(4'h9, 1'b1, 1'b0);
      step(4'h3, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step(4'h3, 1'b1, 1'b0);
      checks++;
      if (delivered.size() != 3) begin
         errors++; $display("[TB] FAIL nochange_count: got %0d expected 3", delivered.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (delivered[i] != exp_vals[i]) begin
               errors++;
               $display("[TB] FAIL nochange_value[%0d]: got %0h expected %0h", i, delivered[i], exp_vals[i]);
            end
         end
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      step(4'h1, 1'b0, 1'b0);
      step(4'h2, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      step(4'h4, 1'b0, 1'b0);
      step(4'h5, 1'b0, 1'b0);
      checks++;
      if (level !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL fill_full: got level %0d ovf %0b expected level 4 ovf 0", level, overflow);
      end
      step(4'h5, 1'b0, 1'b0);
      checks++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         errors++;
         $display("[TB] FAIL fill_overflow: got level %0d ovf %0b expected level 4 ovf 1", level, overflow);
      end
      for (int i = 0; i < 6; i++) step(4'h5, 1'b1, 1'b0);
      checks++;
      if (delivered.size() != 4) begin
         errors++; $display("[TB] FAIL fill_drain_count: got %0d expected 4", delivered.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (delivered[i] != i + 1) begin
               errors++;
               $display("[TB] FAIL fill_drain_value[%0d]: got %0h expected %0h", i, delivered[i], i + 1);
            end
         end
      end
      checks++;
      if (overflow !== 1'b1 || level !== 3'd0) begin
         errors++;
         $display("[TB] FAIL fill_after_drain: got level %0d ovf %0b expected level 0 ovf 1", level, overflow);
      end
   endtask

   task automatic test_full_pop();
      int exp_vals[5];
      exp_vals = '{1, 2, 3, 4, 6};
      do_reset();
      step(4'h1, 1'b0, 1'b0);
      step(4'h2, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      step(4'h4, 1'b0, 1'b0);
      step(4'h4, 1'b0, 1'b0);
      step(4'h6, 1'b0, 1'b0);
      checks++;
      if (level !== 3'd4) begin
         errors++; $display("[TB] FAIL fullpop_prefill: got level %0d expected 4", level);
      end
      step(4'h6, 1'b1, 1'b0);
      checks++;
      if (level !== 3'd4 || overflow !== 1'b0 || out_if.out_data !== 4'h2) begin
         errors++;
         $display("[TB] FAIL fullpop_same_edge: got level %0d ovf %0b data %0h expected 4 0 2",
                  level, overflow, out_if.out_data);
      end
      for (int i = 0; i < 5; i++) step(4'h6, 1'b1, 1'b0);
      checks++;
      if (delivered.size() != 5) begin
         errors++; $display("[TB] FAIL fullpop_count: got %0d expected 5", delivered.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (delivered[i] != exp_vals[i]) begin
               errors++;
               $display("[TB] FAIL fullpop_value[%0d]: got %0h expected %0h", i, delivered[i], exp_vals[i]);
            end
         end
      end
   endtask

   task automatic test_clr_collision();
      do_reset();
      step(4'h1, 1'b0, 1'b0);
      step(4'h2, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      step(4'h4, 1'b0, 1'b0);
      step(4'h4, 1'b0, 1'b0);
      step(4'h7, 1'b0, 1'b0);
      step(4'h7, 1'b0, 1'b1);
      checks++;
      if (overflow !== 1'b1) begin
         errors++; $display("[TB] FAIL clr_set_wins: got %0b expected 1", overflow);
      end
      step(4'h7, 1'b0, 1'b1);
      checks++;
      if (overflow !== 1'b0) begin
         errors++; $display("[TB] FAIL clr_alone: got %0b expected 0", overflow);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(4'h1, 1'b0, 1'b0);
      step(4'h2, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      step(4'h3, 1'b0, 1'b0);
      checks++;
      if (level !== 3'd3) begin
         errors++; $display("[TB] FAIL async_prefill: got level %0d expected 3", level);
      end
      #2;
      reset_l = 1'b0;
      #1;
      checks++;
      if (out_if.out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_immediate: got valid %0b level %0d ovf %0b expected 0 0 0",
                  out_if.out_valid, level, overflow);
      end
      @(negedge clk);
      qvec             = 4'hA;
      out_if.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_l = 1'b1;
      model_reset();
      delivered.delete();
      #1;
      checks++;
      if (out_if.out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL async_release_valid: got %0b expected 0", out_if.out_valid);
      end
      for (int i = 0; i < 4; i++) step(4'hA, 1'b0, 1'b0);
      checks++;
      if (level !== 3'd1 || out_if.out_data !== 4'hA) begin
         errors++;
         $display("[TB] FAIL async_capture: got level %0d data %0h expected level 1 data a",
                  level, out_if.out_data);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 40; i++) begin
         step((i % 2 == 0) ? 4'h1 : 4'h2, 1'b1, 1'b0);
         checks++;
         if (overflow !== 1'b0 || level > 3'd1) begin
            errors++;
            $display("[TB] FAIL b2b_cycle[%0d]: got level %0d ovf %0b expected level<=1 ovf 0",
                     i, level, overflow);
         end
      end
      for (int i = 0; i < 3; i++) step(4'h2, 1'b1, 1'b0);
      checks++;
      if (delivered.size() != 40) begin
         errors++; $display("[TB] FAIL b2b_count: got %0d expected 40", delivered.size());
      end
   endtask

   task automatic test_random();
      logic [3:0] qv;
      logic       rdy;
      logic       clr;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         qv  = 4'($urandom_range(0, 3));
         rdy = ($urandom_range(0, 9) < ((i < 200) ? 3 : 8));
         clr = ($urandom_range(0, 15) == 0);
         step(qv, rdy, clr);
         checks++;
         if (out_if.out_valid !== (m_q.size() > 0)) begin
            errors++;
            $display("[TB] FAIL rand_valid[%0d]: got %0b expected %0b", i, out_if.out_valid, (m_q.size() > 0));
         end
         checks++;
         if (level !== 3'(m_q.size())) begin
            errors++; $display("[TB] FAIL rand_level[%0d]: got %0d expected %0d", i, level, m_q.size());
         end
         checks++;
         if (overflow !== m_ovf) begin
            errors++; $display("[TB] FAIL rand_overflow[%0d]: got %0b expected %0b", i, overflow, m_ovf);
         end
         if (m_q.size() > 0) begin
            checks++;
            if (out_if.out_data !== 4'(m_q[0])) begin
               errors++; $display("[TB] FAIL rand_data[%0d]: got %0h expected %0h", i, out_if.out_data, m_q[0]);
            end
         end
      end
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      reset_l          = 1'b0;
      qvec             = '0;
      out_if.out_ready = 1'b0;
      clr_ovf          = 1'b0;
      model_reset();

      test_reset();
      test_basic_capture();
      test_no_change();
      test_fill_overflow();
      test_full_pop();
      test_clr_collision();
      test_async_reset();
      test_back_to_back();
      test_random();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
